// File: rtl/evu_channel_array.sv
// Event-unit channel array: per-channel event select and prescale, fire records buffered in a FIFO.
// Optional EVU_TIMESTAMP_EN adds a free-running cycle counter stored per record (out_ts_o).
module evu_channel_array #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned SEL_W      = $clog2(NUM_EVENTS),
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ASID_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_EVENTS-1:0]   events_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH*SEL_W-1:0] sel_i,
  input  logic [NUM_CH*CNT_W-1:0] thresh_i,
  input  logic                    cfg_update_i,
  input  logic                    clear_i,
  input  logic [1:0]              priv_lvl_i,
  input  logic [ASID_WIDTH-1:0]   asid_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NUM_CH-1:0]       out_e_id_o,
  output logic [ASID_WIDTH+1:0]   out_e_info_o,
  output logic                    overflow_o,
  output logic [CNT_W-1:0]        drop_cnt_o
`ifdef EVU_TIMESTAMP_EN
  ,
  output logic [31:0]             out_ts_o
`endif
);

  localparam int unsigned INFO_W = ASID_WIDTH + 2;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  logic [NUM_CH-1:0] fire;
  logic [1:0]        priv_enc;
  logic [INFO_W-1:0] info;

  // Per-channel shadow config and prescale counter.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] thresh_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   thr_eff;
    logic             ev;

    assign ev      = (32'(sel_q) < NUM_EVENTS) ? events_i[sel_q] : 1'b0;
    assign thr_eff = (thresh_q == '0) ? (CNT_W+1)'(1) : {1'b0, thresh_q};
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign fire[c] = !cfg_update_i && ch_en_i[c] && ev && (cnt_inc == thr_eff);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sel_q    <= '0;
        thresh_q <= '0;
        cnt_q    <= '0;
      end else if (cfg_update_i) begin
        sel_q    <= sel_i[c*SEL_W +: SEL_W];
        thresh_q <= thresh_i[c*CNT_W +: CNT_W];
        cnt_q    <= '0;
      end else if (ch_en_i[c] && ev) begin
        cnt_q    <= fire[c] ? '0 : cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Privilege context encoding; reserved level maps to 00.
  always_comb begin
    priv_enc = 2'b00;
    case (priv_lvl_i)
      2'b11:   priv_enc = 2'b01;
      2'b01:   priv_enc = 2'b10;
      2'b00:   priv_enc = 2'b11;
      default: priv_enc = 2'b00;
    endcase
  end

  assign info = {priv_enc, asid_i};

  logic [NUM_CH-1:0] mem_id   [FIFO_DEPTH];
  logic [INFO_W-1:0] mem_info [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count_q, count_next;
  logic              valid_q;
  logic              push, pop, full, accept, drop;

  assign push   = |fire;
  assign pop    = valid_q && out_ready_i;
  assign full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    count_next = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
      valid_q <= (count_next != '0);
    end
  end

  // Storage needs no reset; head outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_id[wr_ptr]   <= fire;
      mem_info[wr_ptr] <= info;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_e_id_o   = valid_q ? mem_id[rd_ptr]   : '0;
  assign out_e_info_o = valid_q ? mem_info[rd_ptr] : '0;

  // Drop accounting; a drop in the clear cycle restarts the count at one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= drop;
      drop_cnt_o <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

`ifdef EVU_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_ts[wr_ptr] <= ts_q;
  end

  assign out_ts_o = valid_q ? mem_ts[rd_ptr] : '0;
`else
  // Entries hold only fire bits and context.
`endif

endmodule

// File: tb/tb_evu_channel_array.sv
// Directed self-checking bench for evu_channel_array (default build, 4 channels, depth 4).
module tb_evu_channel_array;

  logic        clk;
  logic        rst;
  logic [15:0] events;
  logic [3:0]  ch_en;
  logic [15:0] sel;
  logic [63:0] thresh;
  logic        cfg_update;
  logic        clear;
  logic [1:0]  priv_lvl;
  logic [15:0] asid;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_e_id;
  logic [17:0] out_e_info;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [1:0] pv [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
  logic [1:0] pe [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  evu_channel_array dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .events_i     (events),
    .ch_en_i      (ch_en),
    .sel_i        (sel),
    .thresh_i     (thresh),
    .cfg_update_i (cfg_update),
    .clear_i      (clear),
    .priv_lvl_i   (priv_lvl),
    .asid_i       (asid),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_e_id_o   (out_e_id),
    .out_e_info_o (out_e_info),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ev);
    events = '0;
    events[ev] = 1'b1;
    tick();
    events = '0;
  endtask

  task automatic load_cfg();
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  initial begin
    rst = 1'b1; events = '0; ch_en = '0; sel = '0; thresh = '0;
    cfg_update = 1'b0; clear = 1'b0; priv_lvl = 2'b11; asid = 16'h005A; out_ready = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_eid", out_e_id, 0);
    chk("rst_info", out_e_info, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // Basic: ch0 sel 3, threshold 0 fires on every event
    sel = 16'h0003; thresh = 64'd0; load_cfg();
    ch_en = 4'b0001;
    chk("t1_pre_valid", out_valid, 0);
    pulse(3);
    chk("t1_valid", out_valid, 1);
    chk("t1_eid", out_e_id, 4'b0001);
    chk("t1_info", out_e_info, 18'h1005A);
    out_ready = 1'b1; tick();
    chk("t1_empty_valid", out_valid, 0);
    chk("t1_empty_eid", out_e_id, 0);

    // Prescale: ch1 sel 2, threshold 3
    sel = 16'h0023; thresh = 64'h0000_0000_0003_0000; load_cfg();
    ch_en = 4'b0010;
    for (int p = 1; p <= 7; p++) begin
      pulse(2);
      chk($sformatf("t2_p%0d_valid", p), out_valid, (p == 3 || p == 6) ? 1 : 0);
      if (p == 3 || p == 6) chk($sformatf("t2_p%0d_eid", p), out_e_id, 4'b0010);
    end
    pulse(2);
    chk("t2_p8_valid", out_valid, 0);
    pulse(2);
    chk("t2_p9_valid", out_valid, 1);
    chk("t2_p9_eid", out_e_id, 4'b0010);
    tick();

    // All channels on event 5, threshold 1; privilege encodings
    sel = 16'h5555; thresh = {4{16'd1}}; load_cfg();
    ch_en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      priv_lvl = pv[k];
      pulse(5);
      chk($sformatf("t3_k%0d_valid", k), out_valid, 1);
      chk($sformatf("t3_k%0d_eid", k), out_e_id, 4'b1111);
      chk($sformatf("t3_k%0d_info", k), out_e_info, {pe[k], 16'h005A});
    end
    priv_lvl = 2'b11;
    tick();
    chk("t3_drain", out_valid, 0);

    // Overflow: 6 fires into a depth-4 FIFO with no consumer
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      asid = 16'(32'h10 + k);
      pulse(5);
      if (k == 4) chk("t4_drop1", drop_cnt, 1);
    end
    chk("t4_ovf", overflow, 1);
    chk("t4_drop2", drop_cnt, 2);
    chk("t4_head0", out_e_info, 18'h10010);
    asid = 16'h0016; clear = 1'b1; pulse(5); clear = 1'b0;
    chk("t4_clrdrop_ovf", overflow, 1);
    chk("t4_clrdrop_cnt", drop_cnt, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t4_clr_ovf", overflow, 0);
    chk("t4_clr_cnt", drop_cnt, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_pop%0d", k), out_e_info, {2'b01, 16'(32'h10 + k)});
      tick();
    end
    chk("t4_empty", out_valid, 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      asid = 16'(32'h20 + k);
      pulse(5);
    end
    asid = 16'h0024; out_ready = 1'b1; pulse(5);
    chk("t5_ovf", overflow, 0);
    chk("t5_drop", drop_cnt, 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t5_pop%0d_valid", k), out_valid, 1);
      chk($sformatf("t5_pop%0d", k), out_e_info, {2'b01, 16'(32'h20 + k)});
      tick();
    end
    chk("t5_empty", out_valid, 0);

    // cfg_update beats a would-be fire and clears counters
    asid = 16'h005A;
    sel = 16'h0003; thresh = 64'd2; load_cfg();
    ch_en = 4'b0001;
    pulse(3);
    chk("t6_cnt1", out_valid, 0);
    sel = 16'h0007; cfg_update = 1'b1; pulse(3); cfg_update = 1'b0;
    chk("t6_nofire", out_valid, 0);
    pulse(3);
    chk("t6_oldsel", out_valid, 0);
    pulse(7);
    chk("t6_cleared", out_valid, 0);
    pulse(7);
    chk("t6_fire", out_valid, 1);
    chk("t6_eid", out_e_id, 4'b0001);
    tick();

    // Disabled channel holds its counter
    ch_en = 4'b0000;
    pulse(7); pulse(7);
    chk("t7_dis", out_valid, 0);
    ch_en = 4'b0001;
    pulse(7);
    chk("t7_hold", out_valid, 0);
    pulse(7);
    chk("t7_fire", out_valid, 1);
    tick();

    // Mid-operation reset empties the FIFO without counting drops
    out_ready = 1'b0;
    pulse(7); pulse(7); pulse(7); pulse(7);
    chk("t8_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t8_rst_valid", out_valid, 0);
    chk("t8_rst_drop", drop_cnt, 0);
    chk("t8_rst_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t8_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/evu_channel_array.md
# evu_channel_array

Parametrised event-unit channel array that sits between the core's event sources (cache/TLB misses, scoreboard full, frontend empty, exceptions, branch resolution, commits) and the SPU event interface. Each of `NUM_CH` channels independently selects one event line, prescales it with a programmable threshold counter, and raises a fire bit. Fire bits from one cycle are bundled with privilege/ASID context into a record, buffered in a FIFO, and delivered over a valid/ready handshake. Dropped records are counted.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `NUM_EVENTS`, 16: width of the event input vector.
- `SEL_W`, `$clog2(NUM_EVENTS)`: derived; per-channel select width.
- `CNT_W`, 16: prescale counter and threshold width.
- `ASID_WIDTH`, 16: ASID field width.
- `FIFO_DEPTH`, 4: record FIFO depth; power of two, ≥2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `events_i`  in  NUM_EVENTS  single-cycle event pulses, one bit per source.
- `ch_en_i`  in  NUM_CH  per-channel enable; live, not shadowed.
- `sel_i`  in  NUM_CH*SEL_W  channel c select in bits [c*SEL_W +: SEL_W].
- `thresh_i`  in  NUM_CH*CNT_W  channel c threshold in bits [c*CNT_W +: CNT_W].
- `cfg_update_i`  in  1  load `sel_i`/`thresh_i` into shadow registers and clear counters.
- `clear_i`  in  1  clear `overflow_o` and `drop_cnt_o`.
- `priv_lvl_i`  in  2  RISC-V privilege (U=00, S=01, M=11).
- `asid_i`  in  ASID_WIDTH  current ASID.
- `out_valid_o`  out  1  FIFO head valid.
- `out_ready_i`  in  1  consumer accepts head.
- `out_e_id_o`  out  NUM_CH  head record fire bits.
- `out_e_info_o`  out  2+ASID_WIDTH  head record {priv_enc, asid}.
- `overflow_o`  out  1  sticky: at least one record dropped.
- `drop_cnt_o`  out  CNT_W  saturating count of dropped records.

## Operation
- Shadow regs: `sel_q[c]`, `thresh_q[c]`. Reset: all 0. Loaded on `cfg_update_i`.
- Channel event: `ev[c] = events_i[sel_q[c]]`; a select ≥ NUM_EVENTS yields 0.
- Counter `cnt[c]` (CNT_W bits, reset 0). Effective threshold `T = (thresh_q[c]==0) ? 1 : thresh_q[c]`.
- If `ch_en_i[c] && ev[c]`: when `cnt[c]+1 == T`, `fire[c]=1` and `cnt[c]<=0`; otherwise `cnt[c]<=cnt[c]+1`. Comparison in CNT_W+1 bits; no wrap.
- `ch_en_i[c]` low: counter holds, no fire.
- `cfg_update_i` wins over counting: all counters cleared, no fire that cycle.
- Priv encoding: M→01, S→10, U→11, 10 (reserved)→00.
- Record = {fire, priv_enc, asid_i}, sampled in the fire cycle. Pushed when `|fire`.
- FIFO: `FIFO_DEPTH` entries, pointer-based, wraps modulo depth. Pop on `out_valid_o && out_ready_i`.
- Push when full without same-cycle pop: record dropped, `overflow_o<=1`, `drop_cnt_o` increments, saturating at all-ones.
- Push when full with same-cycle pop: accepted, no drop.
- `clear_i` clears overflow/drop count. A simultaneous drop wins: `overflow_o=1`, `drop_cnt_o=1`.
- Head outputs are 0 when the FIFO is empty.

## Timing
- Reset values: `out_valid_o=0`, `out_e_id_o=0`, `out_e_info_o=0`, `overflow_o=0`, `drop_cnt_o=0`. All counters, shadows and pointers are 0.
- Event in cycle t: fire is combinational in t, the record is written at the end of t, and `out_valid_o` goes high in t+1 if the FIFO was empty. Latency 1.
- `out_valid_o` is registered state (FIFO non-empty). Head outputs stay stable while `out_valid_o && !out_ready_i`.
- Throughput: one push and one pop per cycle.
- `cfg_update_i` in cycle t: new select/threshold take effect for events in t+1.
- `rst_i` asserted mid-operation: FIFO emptied asynchronously; buffered records are lost and are not counted as drops.

## Configuration
- `EVU_TIMESTAMP_EN` defined:
  - Adds a free-running 32-bit cycle counter (reset 0, wraps).
  - Adds port `out_ts_o` (out, 32) carrying the counter value sampled in each record's fire cycle; stored per FIFO entry.
- Undefined: no counter and no `out_ts_o` port. FIFO entry is {fire, info} only.

## Test plan
- Reset, then sel ch0=3 with thresh 0, `ch_en_i=1`, pulse `events_i[3]` in cycle 5 → `out_valid_o=1` in cycle 6 with `out_e_id_o=4'b0001`; all outputs 0 during reset.
- ch1 sel=2 with thresh=3, 7 pulses on event 2 → fires on pulses 3 and 6 only; `cnt[1]=1` at end.
- Same event selected on all 4 channels with thresh 1, priv M, asid 0x5A → single record `e_id=4'b1111`, `e_info={2'b01,16'h005A}`.
- `out_ready_i=0`, 6 fire cycles with depth 4 → 4 records kept in order; `overflow_o=1`, `drop_cnt_o=2`. Then `clear_i` → both 0, and 4 pops in order.
- FIFO full with push and pop in the same cycle → no drop; occupancy stays 4.
- `cfg_update_i` in the same cycle as an event that would fire (cnt=T-1) → no fire, counters 0, and the new select is active next cycle.
